// File: rtl/fsa_pkg.sv
// Shared types and constants for the frame source arbiter and its pixel packer.
package fsa_pkg;

   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_BLANK  = 2'd1,
      S_ACTIVE = 2'd2
   } fsa_state_e;

   // Full-width colour constants; consumers take the top PIX_W bits.
   localparam logic [15:0] MARKER_R = 16'hFFFF;
   localparam logic [15:0] MARKER_G = 16'h0000;
   localparam logic [15:0] MARKER_B = 16'h0000;
   localparam logic [15:0] ERR_R    = 16'hFFFF;
   localparam logic [15:0] ERR_G    = 16'h0000;
   localparam logic [15:0] ERR_B    = 16'h0000;

   // Write-word layout: {1'b0, 5 bits of G, 10 bits of B or R}.
   localparam int PK_G_W = 5;
   localparam int PK_C_W = 10;

endpackage

// File: rtl/tcon_pixel_pack.sv
// Packs one pixel into the two 16-bit SDRAM write words (G split across both words).
module tcon_pixel_pack
   import fsa_pkg::*;
#(
   parameter int PIX_W = 12
) (
   input  logic [PIX_W-1:0] r,
   input  logic [PIX_W-1:0] g,
   input  logic [PIX_W-1:0] b,
   output logic [15:0]      wr1,
   output logic [15:0]      wr2
);

   assign wr1 = {1'b0, g[PIX_W-1 -: PK_G_W],          b[PIX_W-1 -: PK_C_W]};
   assign wr2 = {1'b0, g[PIX_W-1-PK_G_W -: PK_G_W],   r[PIX_W-1 -: PK_C_W]};

   // Low component bits are dropped by the packed format.
   logic unused_low;
   assign unused_low = &{1'b0, r, g, b};

endmodule

// File: rtl/frame_source_arbiter.sv
// Selects one of NUM_CH pixel sources per frame and emits packed SDRAM write words.
// Optional marker line on mono sources: define FSA_MARKER_EN.
//
// state    | meaning
// S_WAIT   | after reset, waiting for the first blanking period
// S_BLANK  | vertical blanking, source select tracks iSelect
// S_ACTIVE | frame in progress, source select frozen, pixels forwarded
module frame_source_arbiter
   import fsa_pkg::*;
#(
   parameter int                 NUM_CH    = 8,
   parameter int                 PIX_W     = 12,
   parameter int                 COORD_W   = 16,
   parameter logic [NUM_CH-1:0]  MONO_MASK = 8'b0011_1100,
   localparam int                SEL_W     = $clog2(NUM_CH) + 1
) (
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic                      iFval,
   input  logic [SEL_W-1:0]          iSelect,
   input  logic [COORD_W-1:0]        iY_Cont,
   input  logic [NUM_CH*PIX_W-1:0]   iChan_R,
   input  logic [NUM_CH*PIX_W-1:0]   iChan_G,
   input  logic [NUM_CH*PIX_W-1:0]   iChan_B,
   input  logic [NUM_CH-1:0]         iChan_Valid,
   input  logic [7:0]                iMarkerLevel,
   output logic [15:0]               oWr1_data,
   output logic [15:0]               oWr2_data,
   output logic                      oWr_data_valid,
   output logic [SEL_W-1:0]          oActive_Sel,
   output logic                      oSel_Err,
   output logic [31:0]               oFrame_Pix
);

   localparam logic [SEL_W-1:0] NUM_CH_SEL = SEL_W'(NUM_CH);

   fsa_state_e state_q, state_d;

   logic             sel_load;
   logic             frame_end;
   logic             pix_take;

   logic [SEL_W-1:0] active_sel_q;
   logic             sel_err_q;
   logic [31:0]      pix_cnt_q;
   logic [31:0]      frame_pix_q;
   logic             valid_q;
   logic [PIX_W-1:0] r_q, g_q, b_q;

   logic [PIX_W-1:0] ch_r, ch_g, ch_b;
   logic             ch_v, ch_mono;
   logic [PIX_W-1:0] gray_exp;
   logic [PIX_W-1:0] pix_r, pix_g, pix_b;
   logic             pix_v;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= S_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // The cycle that ends a frame (iFval already low) carries no pixel.
   always_comb begin
      state_d   = state_q;
      sel_load  = 1'b0;
      frame_end = 1'b0;
      pix_take  = 1'b0;
      case (state_q)
         S_WAIT: begin
            if (!iFval) begin
               state_d = S_BLANK;
            end
         end
         S_BLANK: begin
            sel_load = 1'b1;
            if (iFval) begin
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (!iFval) begin
               state_d   = S_BLANK;
               frame_end = 1'b1;
            end else begin
               pix_take  = 1'b1;
            end
         end
         default: begin
            state_d = S_WAIT;
         end
      endcase
   end

   always_comb begin
      ch_r    = '0;
      ch_g    = '0;
      ch_b    = '0;
      ch_v    = 1'b0;
      ch_mono = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (active_sel_q == SEL_W'(c)) begin
            ch_r    = iChan_R[c*PIX_W +: PIX_W];
            ch_g    = iChan_G[c*PIX_W +: PIX_W];
            ch_b    = iChan_B[c*PIX_W +: PIX_W];
            ch_v    = iChan_Valid[c];
            ch_mono = MONO_MASK[c];
         end
      end
   end

   assign gray_exp = {ch_r[7:0], {(PIX_W-8){1'b0}}};

`ifdef FSA_MARKER_EN
   logic marker_line;
   assign marker_line = (8'(8'd255 - iY_Cont[7:0]) == iMarkerLevel);
`endif

   logic unused_ins;
   assign unused_ins = &{1'b0, iY_Cont, iMarkerLevel};

   always_comb begin
      pix_v = sel_err_q ? iChan_Valid[0] : ch_v;
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      if (pix_v) begin
         if (sel_err_q) begin
            pix_r = ERR_R[15 -: PIX_W];
            pix_g = ERR_G[15 -: PIX_W];
            pix_b = ERR_B[15 -: PIX_W];
         end else if (ch_mono) begin
            pix_r = gray_exp;
            pix_g = gray_exp;
            pix_b = gray_exp;
`ifdef FSA_MARKER_EN
            if (marker_line) begin
               pix_r = MARKER_R[15 -: PIX_W];
               pix_g = MARKER_G[15 -: PIX_W];
               pix_b = MARKER_B[15 -: PIX_W];
            end
`endif
         end else begin
            pix_r = ch_r;
            pix_g = ch_g;
            pix_b = ch_b;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         active_sel_q <= '0;
         sel_err_q    <= 1'b0;
         pix_cnt_q    <= '0;
         frame_pix_q  <= '0;
         valid_q      <= 1'b0;
         r_q          <= '0;
         g_q          <= '0;
         b_q          <= '0;
      end else begin
         if (sel_load) begin
            active_sel_q <= iSelect;
            sel_err_q    <= (iSelect >= NUM_CH_SEL);
         end

         valid_q <= pix_take & pix_v;
         if (pix_take) begin
            r_q <= pix_r;
            g_q <= pix_g;
            b_q <= pix_b;
         end else begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
         end

         if (frame_end) begin
            frame_pix_q <= pix_cnt_q;
            pix_cnt_q   <= '0;
         end else if (pix_take && pix_v && (pix_cnt_q != '1)) begin
            pix_cnt_q <= pix_cnt_q + 32'd1;
         end
      end
   end

   tcon_pixel_pack #(
      .PIX_W (PIX_W)
   ) u_pack (
      .r   (r_q),
      .g   (g_q),
      .b   (b_q),
      .wr1 (oWr1_data),
      .wr2 (oWr2_data)
   );

   assign oWr_data_valid = valid_q;
   assign oActive_Sel    = active_sel_q;
   assign oSel_Err       = sel_err_q;
   assign oFrame_Pix     = frame_pix_q;

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Bench for frame_source_arbiter: frame-level reference model checked every cycle plus pinned literals.
module tb_frame_source_arbiter;

   localparam int NUM_CH  = 8;
   localparam int PIX_W   = 12;
   localparam int COORD_W = 16;
   localparam int SEL_W   = 4;
   localparam logic [NUM_CH-1:0] MONO = 8'b0011_1100;
   localparam int PIX_MAX = (1 << PIX_W) - 1;

   logic                     iClk = 1'b0;
   logic                     iRst;
   logic                     iFval;
   logic [SEL_W-1:0]         iSelect;
   logic [COORD_W-1:0]       iY_Cont;
   logic [NUM_CH*PIX_W-1:0]  iChan_R, iChan_G, iChan_B;
   logic [NUM_CH-1:0]        iChan_Valid;
   logic [7:0]               iMarkerLevel;
   logic [15:0]              oWr1_data, oWr2_data;
   logic                     oWr_data_valid;
   logic [SEL_W-1:0]         oActive_Sel;
   logic                     oSel_Err;
   logic [31:0]              oFrame_Pix;

   logic [PIX_W-1:0] ch_r [NUM_CH];
   logic [PIX_W-1:0] ch_g [NUM_CH];
   logic [PIX_W-1:0] ch_b [NUM_CH];

   frame_source_arbiter #(
      .NUM_CH    (NUM_CH),
      .PIX_W     (PIX_W),
      .COORD_W   (COORD_W),
      .MONO_MASK (MONO)
   ) dut (
      .iClk           (iClk),
      .iRst           (iRst),
      .iFval          (iFval),
      .iSelect        (iSelect),
      .iY_Cont        (iY_Cont),
      .iChan_R        (iChan_R),
      .iChan_G        (iChan_G),
      .iChan_B        (iChan_B),
      .iChan_Valid    (iChan_Valid),
      .iMarkerLevel   (iMarkerLevel),
      .oWr1_data      (oWr1_data),
      .oWr2_data      (oWr2_data),
      .oWr_data_valid (oWr_data_valid),
      .oActive_Sel    (oActive_Sel),
      .oSel_Err       (oSel_Err),
      .oFrame_Pix     (oFrame_Pix)
   );

   always #5 iClk = ~iClk;

   always_comb begin
      iChan_R = '0;
      iChan_G = '0;
      iChan_B = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         iChan_R[c*PIX_W +: PIX_W] = ch_r[c];
         iChan_G[c*PIX_W +: PIX_W] = ch_g[c];
         iChan_B[c*PIX_W +: PIX_W] = ch_b[c];
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: frame-level bookkeeping, not cycle-by-cycle hardware.
   bit     m_armed;       // a blanking period has been seen since reset
   bit     m_in_frame;    // a frame is open and pixels are being forwarded
   int     m_sel;
   longint m_cnt;
   longint e_fp;
   int     e_sel, e_valid, e_err, e_r, e_g, e_b;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   function automatic bit marker_hit();
`ifdef FSA_MARKER_EN
      return (255 - int'(iY_Cont[7:0])) == int'(iMarkerLevel);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_edge();
      int v, r, g, b, c;
      if (iRst) begin
         m_armed = 0; m_in_frame = 0; m_sel = 0; m_cnt = 0; e_fp = 0;
         e_valid = 0; e_r = 0; e_g = 0; e_b = 0;
      end else begin
         v = 0; r = 0; g = 0; b = 0;
         if (m_in_frame && iFval) begin
            if (m_sel >= NUM_CH) begin
               v = int'(iChan_Valid[0]);
               if (v != 0) r = PIX_MAX;
            end else begin
               c = m_sel;
               v = int'(iChan_Valid[c]);
               if (v != 0) begin
                  if (MONO[c]) begin
                     r = (int'(ch_r[c]) % 256) * (1 << (PIX_W - 8));
                     g = r; b = r;
                     if (marker_hit()) begin r = PIX_MAX; g = 0; b = 0; end
                  end else begin
                     r = int'(ch_r[c]); g = int'(ch_g[c]); b = int'(ch_b[c]);
                  end
               end
            end
            if (v != 0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         end
         e_valid = v; e_r = r; e_g = g; e_b = b;
         if (m_in_frame && !iFval) begin
            e_fp = m_cnt; m_cnt = 0; m_in_frame = 0;
         end else if (m_armed && !m_in_frame) begin
            m_sel = int'(iSelect);
            if (iFval) m_in_frame = 1;
         end else if (!m_armed && !iFval) begin
            m_armed = 1;
         end
      end
      e_sel = m_sel;
      e_err = (m_sel >= NUM_CH) ? 1 : 0;
   endtask

   task automatic compare();
      int w1, w2;
      w1 = ((e_g >> (PIX_W - 5)) << 10) | (e_b >> (PIX_W - 10));
      w2 = (((e_g >> (PIX_W - 10)) % 32) << 10) | (e_r >> (PIX_W - 10));
      chk("valid",      oWr_data_valid, e_valid);
      chk("wr1",        oWr1_data,      w1);
      chk("wr2",        oWr2_data,      w2);
      chk("active_sel", oActive_Sel,    e_sel);
      chk("sel_err",    oSel_Err,       e_err);
      chk("frame_pix",  oFrame_Pix,     e_fp);
   endtask

   task automatic step();
      @(posedge iClk);
      model_edge();
      @(negedge iClk);
      compare();
   endtask

   task automatic rand_data();
      for (int c = 0; c < NUM_CH; c++) begin
         ch_r[c] = PIX_W'($urandom);
         ch_g[c] = PIX_W'($urandom);
         ch_b[c] = PIX_W'($urandom);
      end
   endtask

   initial begin
      iRst = 1'b1; iFval = 1'b0; iSelect = '0; iY_Cont = '0;
      iChan_Valid = '0; iMarkerLevel = 8'd55;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_r[c] = '0; ch_g[c] = '0; ch_b[c] = '0;
      end
      m_armed = 0; m_in_frame = 0; m_sel = 0; m_cnt = 0; e_fp = 0;
      e_sel = 0; e_valid = 0; e_err = 0; e_r = 0; e_g = 0; e_b = 0;

      repeat (3) step();
      chk("rst_sel",   oActive_Sel, 0);
      chk("rst_valid", oWr_data_valid, 0);
      chk("rst_fp",    oFrame_Pix, 0);

      // Mono channel 2, gray 0x5A.
      iRst = 1'b0; iFval = 1'b1; iSelect = 4'd5;
      repeat (2) step();
      chk("wait_no_latch", oActive_Sel, 0);
      iSelect = 4'd2; iFval = 1'b0;
      repeat (2) step();
      chk("blank_latch", oActive_Sel, 2);
      iFval = 1'b1; ch_r[2] = 12'h05A; iChan_Valid = 8'b0000_0100;
      repeat (2) step();
      chk("mono_valid", oWr_data_valid, 1);
      chk("mono_wr1",   oWr1_data, 16'h2D68);

      // Select frozen mid-frame.
      iFval = 1'b0; iSelect = 4'd1;
      step();
      iFval = 1'b1;
      step();
      iSelect = 4'd3;
      for (int i = 0; i < 5; i++) begin
         rand_data(); iChan_Valid = NUM_CH'($urandom); step();
      end
      chk("sel_frozen", oActive_Sel, 1);
      iFval = 1'b0;
      repeat (2) step();
      chk("sel_relatched", oActive_Sel, 3);

      // Out-of-range select.
      iSelect = 4'd9;
      step();
      iFval = 1'b1; iChan_Valid = 8'b0000_0001;
      repeat (2) step();
      chk("err_flag",  oSel_Err, 1);
      chk("err_valid", oWr_data_valid, 1);
      chk("err_wr2",   oWr2_data, 16'h03FF);
      iChan_Valid = 8'b1111_1110;
      step();
      chk("err_invalid", oWr_data_valid, 0);

      // 1000-pixel frame; the first iFval-high cycle only opens the frame.
      iFval = 1'b0; iSelect = 4'd4;
      step();
      iFval = 1'b1; iChan_Valid = '1;
      for (int i = 0; i < 1001; i++) begin
         rand_data(); step();
      end
      iFval = 1'b0;
      step();
      chk("frame_1000", oFrame_Pix, 1000);

      // Reset mid-frame.
      step();
      iFval = 1'b1;
      repeat (10) step();
      iRst = 1'b1;
      step();
      iRst = 1'b0;
      repeat (5) step();
      chk("rst_mid_fp",    oFrame_Pix, 0);
      chk("rst_mid_valid", oWr_data_valid, 0);
      iFval = 1'b0;
      step();

      // Marker line on mono channel 2.
      iSelect = 4'd2; iY_Cont = 16'd200; iMarkerLevel = 8'd55;
      step();
      iFval = 1'b1; ch_r[2] = 12'h033; iChan_Valid = 8'b0000_0100;
      repeat (2) step();
`ifdef FSA_MARKER_EN
      chk("marker_wr1", oWr1_data, 16'h0000);
      chk("marker_wr2", oWr2_data, 16'h03FF);
`else
      chk("nomarker_wr1", oWr1_data, 16'h18CC);
      chk("nomarker_wr2", oWr2_data, 16'h30CC);
`endif
      iY_Cont = 16'd201;
      repeat (2) step();
      chk("offline_wr1", oWr1_data, 16'h18CC);

      // Randomized frames.
      for (int f = 0; f < 60; f++) begin
         iFval = 1'b0;
         for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
            iSelect = SEL_W'($urandom);
            iRst = ($urandom_range(0, 149) == 0);
            step();
         end
         iFval = 1'b1;
         for (int i = 0; i < int'($urandom_range(5, 40)); i++) begin
            rand_data();
            iChan_Valid = NUM_CH'($urandom);
            iSelect = SEL_W'($urandom);
            iY_Cont = COORD_W'($urandom_range(195, 205));
            iRst = ($urandom_range(0, 149) == 0);
            step();
         end
      end
      iRst = 1'b0; iFval = 1'b0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
